// File: rtl/surv_mem_pkg.sv
// Shared constants, types and helpers for the survivor ring memory.
// Age-to-address math lives here so the top stays free of wrap arithmetic.
package surv_mem_pkg;

    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 10;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    localparam bit RDW_MODE_OLD = 1'b0;
    localparam bit RDW_MODE_NEW = 1'b1;

    typedef logic [DW_DEF-1:0] dec_word_t;

    // Steps-back-from-newest to absolute slot, modulo 2**aw.
    function automatic logic [31:0] age_to_addr(
        input logic [31:0] wptr,
        input logic [31:0] back,
        input int          aw
    );
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (wptr - 32'd1 - back) & mask;
    endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: synchronous write, synchronous read, no reset.
// A same-address read and write in one cycle returns the old word.
module ram_sdp #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/surv_ring_mem.sv
// Survivor-decision ring buffer read by age for Viterbi traceback.
// Tracks fill, flags out-of-range reads, optional extra output stage.
module surv_ring_mem
    import surv_mem_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter bit RDW_NEW = RDW_MODE_OLD,
    parameter int RD_LAT  = RD_LAT_MIN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_back,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    output logic          rd_err,
    output logic [AW:0]   fill,
    output logic          full
);

    localparam int        DEPTH   = 2**AW;
    localparam logic [AW:0] DEPTH_F = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   fill_q;
    logic          wr_ok;
    logic          req_ok;
    logic          rd_oor;
    logic          coll;
    logic [DW-1:0] ram_q;

    assign wr_ok  = wr_en & ~clr;
    assign req_ok = rd_req & ~clr;
    assign raddr  = AW'(age_to_addr(32'(wptr), 32'(rd_back), AW));
    assign rd_oor = ({1'b0, rd_back} >= fill_q);
    assign coll   = wr_ok & req_ok & (raddr == wptr);

    ram_sdp #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_ok),
        .wr_addr(wptr),
        .wr_data(wr_data),
        .rd_en  (req_ok & ~rd_oor),
        .rd_addr(raddr),
        .rd_data(ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            fill_q <= '0;
        end else if (clr) begin
            wptr   <= '0;
            fill_q <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (fill_q != DEPTH_F) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign fill = fill_q;
    assign full = (fill_q == DEPTH_F);

    // Output-select flags only move on accepted requests, so data holds.
    logic          v1;
    logic          e1;
    logic          sel_zero;
    logic          sel_byp;
    logic [DW-1:0] byp_q;
    logic [DW-1:0] data1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            e1       <= 1'b0;
            sel_zero <= 1'b1;
            sel_byp  <= 1'b0;
            byp_q    <= '0;
        end else begin
            v1 <= req_ok;
            e1 <= req_ok & rd_oor;
            if (req_ok) begin
                sel_zero <= rd_oor;
                sel_byp  <= coll && (RDW_NEW != 1'b0);
                byp_q    <= wr_data;
            end
        end
    end

    assign data1 = sel_zero ? '0 : (sel_byp ? byp_q : ram_q);

    generate
        if (RD_LAT == RD_LAT_MAX) begin : g_lat2
            logic          v2;
            logic          e2;
            logic [DW-1:0] d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else if (clr) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    if (v1) begin
                        d2 <= data1;
                    end
                end
            end

            assign rd_vld  = v2;
            assign rd_err  = e2;
            assign rd_data = d2;
        end else begin : g_lat1
            assign rd_vld  = v1;
            assign rd_err  = e1;
            assign rd_data = data1;
        end
    endgenerate

endmodule
